ps2_scancode_controller: RTL and testbench
==========================================

Name: ps2_scancode_controller

Overview:
- Sits directly behind the PS2Keyboard receiver and consumes its (valid_data, data) byte stream.
- Sequences multi-byte PS/2 Set-2 scan-code sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Filters keyboard status bytes into sticky status flags.
- Buffers key events in a small FIFO with a valid/ready handshake toward the central unit.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000, clock cycles a partial sequence may idle before it is discarded (2 ms at 25 MHz).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle strobe from the receiver's valid_data.
- rx_data  input  8  received byte from the receiver's data, qualified by rx_valid.
- event_valid  output  1  FIFO head holds an event.
- event_ready  input  1  consumer accepts the head event when both valid and ready are high.
- event_code  output  8  scan code of the head event.
- event_extended  output  1  head event was E0-prefixed.
- event_released  output  1  head event is a break (key release).
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- bat_passed  output  1  sticky: 8'hAA received.
- kbd_error  output  1  sticky: 8'h00, 8'hFF or 8'hFC received.
- clear_status  input  1  synchronous clear of the three sticky flags.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO empty, timeout counter=0, pause counter=0.
  - event_valid=0, event_code=0, event_extended=0, event_released=0.
  - overflow=0, bat_passed=0, kbd_error=0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. All transitions occur only on rx_valid, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, with the pause counter loaded to 7.
  - AA -> set bat_passed.
  - 00, FF, FC -> set kbd_error.
  - FA, EE, FE -> ignored.
  - Any other byte b -> push {code=b, ext=0, rel=0}.
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT; other b -> push {b,1,0}, go to IDLE.
- BRK: b -> push {b,0,1}, go to IDLE.
- EXT_BRK: b -> push {b,1,1}, go to IDLE.
- PAUSE:
  - Each byte decrements the pause counter; byte contents are not checked.
  - When the counter reaches 0, push {8'hE1,0,0} and go to IDLE.
- Status bytes are interpreted only in IDLE; in other states they are treated as data.
- Timeout:
  - In any non-IDLE state the counter increments on every cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, discard the partial sequence, emit no event.
  - The counter is held at 0 in IDLE.
- Latency: an event is written at the clock edge that samples the final byte's rx_valid. event_valid is high the following cycle (1-cycle latency, first-word-fall-through).
- FIFO:
  - Pop when event_valid && event_ready.
  - Push when full without a simultaneous pop: event dropped, overflow=1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop when empty is not possible because there is no bypass.
  - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full/empty are derived from the MSB comparison.
- Outputs event_code, event_extended and event_released are held stable while event_valid && !event_ready.
- clear_status has priority below a set in the same cycle: a simultaneous set wins.
- Reset mid-sequence or with FIFO contents: everything is discarded immediately. No events are emitted after reset is released until new bytes arrive.

Decomposition:
- Package ps2_pkg holds:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT_OK=8'hAA, PS2_BAT_FAIL=8'hFC, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - the FSM state encoding;
  - the 10-bit event record {extended, released, code[7:0]}.
- Sub-module ps2_event_fifo: synchronous FIFO, parameter DEPTH and width 10. Exposes push, full, pop, empty and head data.

Test Plan:
- Bytes 1C with event_ready=1 -> one event {code=1C, ext=0, rel=0}, event_valid high exactly 1 cycle after the rx_valid edge.
- Bytes F0,1C then E0,F0,75 -> events {1C,0,1} then {75,1,1}; no event is produced for any prefix byte.
- Byte E0, then TIMEOUT_CYCLES idle cycles, then 1C -> single event {1C,0,0}.
- event_ready=0, bytes 15,35,AB,1C,2D -> 4 events buffered in order (15,35,AB,1C); 2D dropped; overflow=1. Then release ready -> 4 pops, event_valid falls.
- Bytes AA, then FC, then F1 -> bat_passed=1, kbd_error=1, one event {F1,0,0}. clear_status pulse -> both flags 0.
- Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event {E1,0,0}. Assert reset after E1,14 -> state IDLE, FIFO empty; subsequent 1C -> {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 Set-2 scan-code controller:
//   - byte values with special meaning in the keyboard-to-host stream
//   - sequencer state encoding
//   - the 10-bit key event record {extended, released, code}
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_ERR0     = 8'h00;
    localparam logic [7:0] PS2_ERR1     = 8'hFF;

    // Bytes that follow E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

    localparam int EVENT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } ps2_state_e;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_kbd_error(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT_FAIL);
    endfunction

    // Command responses carry no key information and are dropped silently.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous first-word-fall-through FIFO for key event records.
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   push, push_data  : write request and record; ignored when full unless a
//                      pop happens in the same cycle
//   full, empty      : occupancy status
//   pop              : remove head entry (ignored when empty)
//   head_data        : current head record, valid whenever !empty
// ---------------------------------------------------------------------------
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot the simultaneous push lands in, so full+pop+push
    // is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Combinational head read gives first-word-fall-through behaviour.
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_controller.sv
// ---------------------------------------------------------------------------
// ps2_scancode_controller
// Turns the PS/2 receiver byte stream into key events.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   rx_valid, rx_data   : one-cycle byte strobe and byte from the receiver
//   event_valid/ready   : handshake toward the consumer, head of event FIFO
//   event_code          : scan code of the head event (0 when empty)
//   event_extended      : head event carried the E0 prefix
//   event_released      : head event is a key release (F0 prefix)
//   overflow            : sticky, an event was dropped on a full FIFO
//   bat_passed          : sticky, self-test pass byte AA seen
//   kbd_error           : sticky, error byte 00/FF/FC seen
//   clear_status        : clears the sticky flags (a same-cycle set wins)
// ---------------------------------------------------------------------------
module ps2_scancode_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_released,
    output logic       overflow,
    output logic       bat_passed,
    output logic       kbd_error,
    input  logic       clear_status
);

    localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [2:0]    pause_q, pause_d;
    logic          overflow_q, overflow_d;
    logic          bat_q, bat_d;
    logic          err_q, err_d;

    logic          push;
    ps2_event_t    push_evt;
    logic          set_bat, set_err;

    logic          fifo_full, fifo_empty, pop, drop;
    logic [EVENT_W-1:0] head_data;
    ps2_event_t    head_evt;

    // Sequencer: prefixes steer state, the final byte of a sequence pushes.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        pause_d   = pause_q;
        push      = 1'b0;
        push_evt  = '0;
        set_bat   = 1'b0;
        set_err   = 1'b0;

        if (rx_valid) begin
            timeout_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state_d = EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state_d = BRK;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_d = PAUSE;
                        pause_d = PAUSE_TAIL_BYTES;
                    end else if (rx_data == PS2_BAT_OK) begin
                        set_bat = 1'b1;
                    end else if (is_kbd_error(rx_data)) begin
                        set_err = 1'b1;
                    end else if (!is_ignored(rx_data)) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b0, released: 1'b0, code: rx_data};
                    end
                end
                EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data != PS2_EXT) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b1, released: 1'b0, code: rx_data};
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    push     = 1'b1;
                    push_evt = '{extended: 1'b0, released: 1'b1, code: rx_data};
                    state_d  = IDLE;
                end
                EXT_BRK: begin
                    push     = 1'b1;
                    push_evt = '{extended: 1'b1, released: 1'b1, code: rx_data};
                    state_d  = IDLE;
                end
                PAUSE: begin
                    // The byte that takes the counter from 1 to 0 completes Pause.
                    if (pause_q == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{extended: 1'b0, released: 1'b0, code: PS2_PAUSE};
                        state_d  = IDLE;
                        pause_d  = '0;
                    end else begin
                        pause_d = pause_q - 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Abandon a partial sequence the keyboard never finished.
            if (timeout_q == TIMEOUT_LAST) begin
                state_d   = IDLE;
                timeout_d = '0;
                pause_d   = '0;
            end else begin
                timeout_d = timeout_q + TW'(1);
            end
        end
    end

    assign pop  = !fifo_empty && event_ready;
    assign drop = push && fifo_full && !pop;

    // Sticky flags: a set in the same cycle overrides clear_status.
    always_comb begin
        overflow_d = clear_status ? 1'b0 : overflow_q;
        bat_d      = clear_status ? 1'b0 : bat_q;
        err_d      = clear_status ? 1'b0 : err_q;
        if (drop)    overflow_d = 1'b1;
        if (set_bat) bat_d      = 1'b1;
        if (set_err) err_d      = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timeout_q  <= '0;
            pause_q    <= '0;
            overflow_q <= 1'b0;
            bat_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timeout_q  <= timeout_d;
            pause_q    <= pause_d;
            overflow_q <= overflow_d;
            bat_q      <= bat_d;
            err_q      <= err_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    // Head fields are forced to zero while empty so stale storage never shows.
    assign head_evt       = ps2_event_t'(head_data);
    assign event_valid    = !fifo_empty;
    assign event_code     = fifo_empty ? 8'h00 : head_evt.code;
    assign event_extended = !fifo_empty && head_evt.extended;
    assign event_released = !fifo_empty && head_evt.released;

    assign overflow   = overflow_q;
    assign bat_passed = bat_q;
    assign kbd_error  = err_q;

endmodule

// File: tb/tb_ps2_scancode_controller.sv
module tb_ps2_scancode_controller;

    localparam int T     = 20;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       event_valid;
    logic       event_ready = 1'b0;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_released;
    logic       overflow;
    logic       bat_passed;
    logic       kbd_error;
    logic       clear_status = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state: pending prefix bytes, expected events, flags.
    logic [7:0] pend[$];
    logic [9:0] exp_q[$];
    logic       m_bat = 1'b0;
    logic       m_err = 1'b0;
    logic       mon_en = 1'b0;

    ps2_scancode_controller #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_code     (event_code),
        .event_extended (event_extended),
        .event_released (event_released),
        .overflow       (overflow),
        .bat_passed     (bat_passed),
        .kbd_error      (kbd_error),
        .clear_status   (clear_status)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic ext, input logic rel, input logic [7:0] code);
        check(tag, {21'd0, event_valid, event_extended, event_released, event_code},
                   {21'd0, 1'b1, ext, rel, code});
    endtask

    task automatic check_none(input string tag);
        check(tag, {31'd0, event_valid}, 32'd0);
    endtask

    // All operations start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
    endtask

    // Byte-level reference: what a Set-2 decoder should make of each byte.
    task automatic model_byte(input logic [7:0] b);
        if (pend.size() == 0) begin
            case (b)
                8'hE0, 8'hF0, 8'hE1: pend.push_back(b);
                8'hAA:               m_bat = 1'b1;
                8'h00, 8'hFF, 8'hFC: m_err = 1'b1;
                8'hFA, 8'hEE, 8'hFE: ;
                default:             exp_q.push_back({2'b00, b});
            endcase
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                exp_q.push_back({2'b00, 8'hE1});
                pend.delete();
            end
        end else if (pend[pend.size()-1] == 8'hF0) begin
            exp_q.push_back({pend[0] == 8'hE0, 1'b1, b});
            pend.delete();
        end else if (b == 8'hE0 || b == 8'hF0) begin
            pend.push_back(b);
        end else begin
            exp_q.push_back({2'b10, b});
            pend.delete();
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL rand_unexpected: observed event %0h expected none",
                           {event_extended, event_released, event_code});
                end
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("rand_event", {22'd0, event_extended, event_released, event_code}, {22'd0, e});
            end
        end
    end

    initial begin
        logic [7:0] codes[4];
        logic [7:0] pause_seq[8];
        logic [7:0] b;
        int         r, g, gap;

        // Reset state
        idle(2);
        check("reset_outputs", {21'd0, event_valid, event_code, event_extended, event_released,
                                overflow, bat_passed, kbd_error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(1);

        // Single make code, one-cycle latency
        event_ready = 1'b1;
        check_none("pre_1c");
        send(8'h1C);
        check_evt("make_1c", 1'b0, 1'b0, 8'h1C);
        idle(1);
        check_none("popped_1c");

        // Break and extended break
        send(8'hF0);            check_none("prefix_f0");
        send(8'h1C);            check_evt("break_1c", 1'b0, 1'b1, 8'h1C);
        send(8'hE0);            check_none("prefix_e0");
        send(8'hF0);            check_none("prefix_e0f0");
        send(8'h75);            check_evt("ext_break_75", 1'b1, 1'b1, 8'h75);

        // Timeout boundary: T idle cycles discard, T-1 do not
        send(8'hE0);            check_none("to_prefix");
        idle(T);
        send(8'h1C);            check_evt("timeout_discard", 1'b0, 1'b0, 8'h1C);
        send(8'hE0);
        idle(T - 1);
        send(8'h1C);            check_evt("timeout_edge", 1'b1, 1'b0, 8'h1C);
        idle(1);

        // Overflow with a stalled consumer; head held stable
        event_ready = 1'b0;
        codes = '{8'h15, 8'h35, 8'hAB, 8'h1C};
        for (int i = 0; i < 4; i++) send(codes[i]);
        check("no_ovf_yet", {31'd0, overflow}, 32'd0);
        send(8'h2D);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        idle(2);
        check_evt("head_stable", 1'b0, 1'b0, 8'h15);
        event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_evt("drain_ovf", 1'b0, 1'b0, codes[i]);
            idle(1);
        end
        check_none("drained_ovf");
        pulse_clear();
        check("overflow_clear", {31'd0, overflow}, 32'd0);

        // Push and pop together while full: both succeed
        event_ready = 1'b0;
        codes = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) send(codes[i]);
        event_ready = 1'b1;
        send(8'h16);
        check("full_push_pop_ovf", {31'd0, overflow}, 32'd0);
        codes = '{8'h12, 8'h13, 8'h14, 8'h16};
        for (int i = 0; i < 4; i++) begin
            check_evt("drain_full", 1'b0, 1'b0, codes[i]);
            idle(1);
        end
        check_none("drained_full");

        // Status flags
        send(8'hAA);
        check("bat_set", {31'd0, bat_passed}, 32'd1);
        check_none("bat_no_event");
        send(8'hFC);
        check("err_set", {31'd0, kbd_error}, 32'd1);
        send(8'hF1);            check_evt("make_f1", 1'b0, 1'b0, 8'hF1);
        clear_status = 1'b1;
        send(8'hAA);
        clear_status = 1'b0;
        check("set_beats_clear", {30'd0, bat_passed, kbd_error}, 32'd2);
        pulse_clear();
        check("flags_cleared", {30'd0, bat_passed, kbd_error}, 32'd0);
        send(8'hFA); send(8'hEE); send(8'hFE);
        check_none("ignored_bytes");
        send(8'hF0); send(8'hAA);
        check_evt("aa_as_data", 1'b0, 1'b1, 8'hAA);
        check("aa_data_no_bat", {31'd0, bat_passed}, 32'd0);
        idle(1);

        // Pause sequence
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) send(pause_seq[i]);
        check_none("pause_partial");
        send(pause_seq[7]);
        check_evt("pause_event", 1'b0, 1'b0, 8'hE1);
        idle(1);
        check_none("pause_single");

        // Reset mid-sequence with FIFO contents
        event_ready = 1'b0;
        send(8'hAA);
        send(8'h22);
        send(8'hE1);
        send(8'h14);
        reset = 1'b0;
        #2;
        check("reset_mid", {21'd0, event_valid, event_code, event_extended, event_released,
                            overflow, bat_passed, kbd_error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(3);
        check_none("post_reset_quiet");
        event_ready = 1'b1;
        send(8'h1C);
        check_evt("post_reset_1c", 1'b0, 1'b0, 8'h1C);
        pulse_clear();

        // Randomized stream against the reference model
        mon_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'hAA;
                6:       b = (($urandom_range(0, 2) == 0) ? 8'h00 :
                              ($urandom_range(0, 1) == 0) ? 8'hFF : 8'hFC);
                7:       b = (($urandom_range(0, 2) == 0) ? 8'hFA :
                              ($urandom_range(0, 1) == 0) ? 8'hEE : 8'hFE);
                default: b = 8'($urandom_range(0, 255));
            endcase
            g = $urandom_range(0, 9);
            case (g)
                0, 1, 2, 3, 4: gap = 0;
                5, 6:          gap = $urandom_range(1, 3);
                7:             gap = T - 1;
                8:             gap = T;
                default:       gap = T + 2;
            endcase
            idle(gap);
            if (gap >= T) pend.delete();
            model_byte(b);
            send(b);
        end
        idle(3);
        mon_en = 1'b0;
        check("rand_all_seen", exp_q.size(), 32'd0);
        check("rand_flags", {29'd0, overflow, bat_passed, kbd_error}, {29'd0, 1'b0, m_bat, m_err});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
